// File: rtl/priority_arbiter_pkg.sv
// Shared types for the priority arbiter: arbitration mode and handshake state.
package priority_arbiter_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/priority_arbiter_pick.sv
// Combinational winner search: highest set bit (fixed) or first set bit at/after
// start with wrap-around (round-robin).
module priority_pick
  import priority_arbiter_pkg::*;
#(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  input  mode_e        mode,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [W:0] pos_s;

  // Winner search; later loop iterations override earlier ones, so loop order sets priority
  always_comb begin
    idx   = '0;
    pos_s = '0;
    case (mode)
      MODE_FIXED: begin
        for (int i = 0; i < N; i++) begin
          idx = req[i] ? W'(i) : idx;
        end
      end
      MODE_RR: begin
        // Walk offsets downward so the smallest offset from start wins
        for (int k = N - 1; k >= 0; k--) begin
          pos_s = {1'b0, start} + (W+1)'(k);
          if (pos_s >= (W+1)'(N)) begin
            pos_s = pos_s - (W+1)'(N);
          end else begin
            pos_s = pos_s;
          end
          idx = req[pos_s[W-1:0]] ? pos_s[W-1:0] : idx;
        end
      end
      default: idx = '0;
    endcase
  end

  assign any = |req;

endmodule

// File: rtl/priority_arbiter.sv
// Fixed/round-robin priority arbiter with a registered valid/ready grant output
// that issues back-to-back grants on handshake and never retracts a pending grant.
module priority_arbiter
  import priority_arbiter_pkg::*;
#(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] grant_idx,
  output logic [N-1:0] grant_onehot,
  output logic         none
);

  state_e       state_r, state_n_s;
  logic [W-1:0] ptr_r, ptr_n_s, ptr_inc_s;
  logic [W-1:0] grant_idx_r, grant_idx_n_s, win_s;
  logic [N-1:0] grant_onehot_r, grant_onehot_n_s;
  logic         out_valid_r, out_valid_n_s;
  logic         none_r, none_n_s;
  logic         any_s, sel_s, hs_s;
  mode_e        mode_s;

  assign mode_s    = mode_e'(mode);
  assign hs_s      = (state_r == HOLD) && out_ready;
  assign ptr_inc_s = (grant_idx_r == W'(N - 1)) ? '0 : grant_idx_r + W'(1);

  // Pointer advances past the accepted grant; the same value seeds this cycle's search
  always_comb begin
    ptr_n_s = ptr_r;
    if (hs_s && (mode_s == MODE_RR)) begin
      ptr_n_s = ptr_inc_s;
    end else begin
      ptr_n_s = ptr_r;
    end
  end

  priority_pick #(.N(N), .W(W)) u_pick (
    .req   (req),
    .start (ptr_n_s),
    .mode  (mode_s),
    .idx   (win_s),
    .any   (any_s)
  );

  // Next state and next registered outputs
  always_comb begin
    sel_s            = 1'b0;
    state_n_s        = state_r;
    out_valid_n_s    = out_valid_r;
    grant_idx_n_s    = grant_idx_r;
    grant_onehot_n_s = grant_onehot_r;
    none_n_s         = none_r;
    case (state_r)
      IDLE:    sel_s = 1'b1;
      HOLD:    sel_s = out_ready;
      default: sel_s = 1'b1;
    endcase
    if (sel_s) begin
      if (any_s) begin
        state_n_s        = HOLD;
        out_valid_n_s    = 1'b1;
        grant_idx_n_s    = win_s;
        grant_onehot_n_s = N'(1) << win_s;
        none_n_s         = 1'b0;
      end else begin
        state_n_s        = IDLE;
        out_valid_n_s    = 1'b0;
        grant_onehot_n_s = '0;
        none_n_s         = 1'b1;
      end
    end else begin
      state_n_s = state_r;
    end
  end

  // State, pointer and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      ptr_r          <= '0;
      out_valid_r    <= 1'b0;
      grant_idx_r    <= '0;
      grant_onehot_r <= '0;
      none_r         <= 1'b1;
    end else begin
      state_r        <= state_n_s;
      ptr_r          <= ptr_n_s;
      out_valid_r    <= out_valid_n_s;
      grant_idx_r    <= grant_idx_n_s;
      grant_onehot_r <= grant_onehot_n_s;
      none_r         <= none_n_s;
    end
  end

  assign out_valid    = out_valid_r;
  assign grant_idx    = grant_idx_r;
  assign grant_onehot = grant_onehot_r;
  assign none         = none_r;

endmodule

// File: tb/tb_priority_arbiter.sv
// Self-checking bench for priority_arbiter (N=8 and N=5 instances) using
// per-cycle expectation queues fed by a behavioural model or fixed tables.
module tb_priority_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req8 = 8'h00;
  logic       mode8 = 1'b0, rdy8 = 1'b0;
  logic       v8, none8;
  logic [2:0] idx8;
  logic [7:0] oh8;
  logic [4:0] req5 = 5'h00;
  logic       mode5 = 1'b0, rdy5 = 1'b0;
  logic       v5, none5;
  logic [2:0] idx5;
  logic [4:0] oh5;

  int n_checks = 0;
  int n_pass = 0;

  typedef struct packed {logic v; logic [2:0] idx; logic [7:0] oh; logic nn;} exp8_t;
  typedef struct packed {logic v; logic [2:0] idx; logic [4:0] oh; logic nn;} exp5_t;
  exp8_t sb8[$];
  exp5_t sb5[$];

  logic       m_v, m_none;
  logic [2:0] m_idx;
  int         m_ptr;

  always #5 clk = ~clk;

  priority_arbiter #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .req(req8), .mode(mode8), .out_ready(rdy8),
    .out_valid(v8), .grant_idx(idx8), .grant_onehot(oh8), .none(none8)
  );

  priority_arbiter #(.N(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .req(req5), .mode(mode5), .out_ready(rdy5),
    .out_valid(v5), .grant_idx(idx5), .grant_onehot(oh5), .none(none5)
  );

  task automatic model_reset();
    m_v = 1'b0; m_none = 1'b1; m_idx = 3'd0; m_ptr = 0;
  endtask

  // Drive one cycle of N=8 stimulus and queue the expected post-edge outputs
  task automatic drive8(input logic [7:0] r, input logic md, input logic rdy);
    logic sel;
    int w;
    exp8_t e;
    req8 = r; mode8 = md; rdy8 = rdy;
    sel = !m_v || rdy;
    if (m_v && rdy && md) m_ptr = (m_idx + 1) % 8;
    if (sel) begin
      if (r == 8'h00) begin
        m_v = 1'b0; m_none = 1'b1;
      end else begin
        w = 0;
        if (!md) begin
          for (int i = 0; i < 8; i++) if (r[i]) w = i;
        end else begin
          for (int off = 7; off >= 0; off--) if (r[(m_ptr + off) % 8]) w = (m_ptr + off) % 8;
        end
        m_v = 1'b1; m_none = 1'b0; m_idx = w[2:0];
      end
    end
    e.v = m_v; e.idx = m_idx; e.oh = m_v ? (8'b1 << m_idx) : 8'b0; e.nn = m_none;
    sb8.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req8 = 8'h00; mode8 = 1'b0; rdy8 = 1'b0;
    req5 = 5'h00; mode5 = 1'b0; rdy5 = 1'b0;
    model_reset();
    sb8.delete(); sb5.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp8_t e;
    rst_n = 1'b0;
    model_reset();
    #12;
    n_checks++;
    if ({v8, idx8, oh8, none8} !== {1'b0, 3'd0, 8'h00, 1'b1})
      $display("FAIL reset_hold8: got %b want %b", {v8, idx8, oh8, none8}, {1'b0, 3'd0, 8'h00, 1'b1});
    else n_pass++;
    n_checks++;
    if ({v5, idx5, oh5, none5} !== {1'b0, 3'd0, 5'h00, 1'b1})
      $display("FAIL reset_hold5: got %b want %b", {v5, idx5, oh5, none5}, {1'b0, 3'd0, 5'h00, 1'b1});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive8(8'h00, 1'b0, 1'b0);
      @(posedge clk); #1;
      e = sb8.pop_front();
      n_checks++;
      if ({v8, idx8, oh8, none8} !== e)
        $display("FAIL reset_release: got %b want %b", {v8, idx8, oh8, none8}, e);
      else n_pass++;
    end
  endtask

  task automatic test_fixed();
    exp8_t e;
    for (int k = 0; k < 6; k++) begin
      drive8(8'b0010_0110, 1'b0, 1'b1);
      @(posedge clk); #1;
      e = sb8.pop_front();
      n_checks++;
      if ({v8, idx8, oh8, none8} !== e)
        $display("FAIL fixed_sb: got %b want %b", {v8, idx8, oh8, none8}, e);
      else n_pass++;
      n_checks++;
      if ({v8, idx8} !== {1'b1, 3'd5})
        $display("FAIL fixed_idx: got v=%0b idx=%0d want v=1 idx=5", v8, idx8);
      else n_pass++;
    end
  endtask

  task automatic test_rr_sweep();
    exp8_t e;
    logic [2:0] want;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      want = 3'(k % 8);
      drive8(8'hFF, 1'b1, 1'b1);
      @(posedge clk); #1;
      e = sb8.pop_front();
      n_checks++;
      if ({v8, idx8, oh8, none8} !== e)
        $display("FAIL rr_sweep_sb: got %b want %b", {v8, idx8, oh8, none8}, e);
      else n_pass++;
      n_checks++;
      if ({v8, idx8} !== {1'b1, want})
        $display("FAIL rr_sweep_idx: got v=%0b idx=%0d want v=1 idx=%0d", v8, idx8, want);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    exp8_t e;
    drive8(8'b0000_1000, 1'b0, 1'b1);
    @(posedge clk); #1;
    e = sb8.pop_front();
    n_checks++;
    if ({v8, idx8, oh8, none8} !== {1'b1, 3'd3, 8'h08, 1'b0})
      $display("FAIL stall_grant: got %b want %b", {v8, idx8, oh8, none8}, e);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      drive8(8'h00, 1'(k), 1'b0);
      @(posedge clk); #1;
      e = sb8.pop_front();
      n_checks++;
      if ({v8, idx8, oh8, none8} !== {1'b1, 3'd3, 8'h08, 1'b0})
        $display("FAIL stall_hold: got %b want %b", {v8, idx8, oh8, none8}, {1'b1, 3'd3, 8'h08, 1'b0});
      else n_pass++;
    end
    drive8(8'h00, 1'b0, 1'b1);
    @(posedge clk); #1;
    e = sb8.pop_front();
    n_checks++;
    if ({v8, idx8, oh8, none8} !== {1'b0, 3'd3, 8'h00, 1'b1})
      $display("FAIL stall_release: got %b want %b", {v8, idx8, oh8, none8}, e);
    else n_pass++;
  endtask

  task automatic test_reset_mid_hold();
    exp8_t e;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      drive8(8'hFF, 1'b1, 1'b1);
      @(posedge clk); #1;
      e = sb8.pop_front();
      n_checks++;
      if ({v8, idx8} !== {1'b1, 3'(k)})
        $display("FAIL midrst_pre: got v=%0b idx=%0d want v=1 idx=%0d", v8, idx8, k);
      else n_pass++;
    end
    rdy8 = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({v8, idx8, oh8, none8} !== {1'b0, 3'd0, 8'h00, 1'b1})
      $display("FAIL midrst_clear: got %b want %b", {v8, idx8, oh8, none8}, {1'b0, 3'd0, 8'h00, 1'b1});
    else n_pass++;
    do_reset();
    drive8(8'hFF, 1'b1, 1'b1);
    @(posedge clk); #1;
    e = sb8.pop_front();
    n_checks++;
    if ({v8, idx8, oh8, none8} !== {1'b1, 3'd0, 8'h01, 1'b0})
      $display("FAIL midrst_after: got %b want %b", {v8, idx8, oh8, none8}, e);
    else n_pass++;
  endtask

  task automatic test_wrap5();
    logic [4:0] reqs [6] = '{5'b01000, 5'b00000, 5'b10001, 5'b10001, 5'b10001, 5'b10001};
    exp5_t wants [6] = '{
      {1'b1, 3'd3, 5'b01000, 1'b0}, {1'b0, 3'd3, 5'b00000, 1'b1},
      {1'b1, 3'd4, 5'b10000, 1'b0}, {1'b1, 3'd0, 5'b00001, 1'b0},
      {1'b1, 3'd4, 5'b10000, 1'b0}, {1'b1, 3'd0, 5'b00001, 1'b0}};
    exp5_t e;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      req5 = reqs[k]; mode5 = 1'b1; rdy5 = 1'b1;
      sb5.push_back(wants[k]);
      @(posedge clk); #1;
      e = sb5.pop_front();
      n_checks++;
      if ({v5, idx5, oh5, none5} !== e)
        $display("FAIL wrap5_step%0d: got %b want %b", k, {v5, idx5, oh5, none5}, e);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    exp8_t e;
    logic [7:0] r;
    do_reset();
    for (int k = 0; k < 80; k++) begin
      r = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      drive8(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0));
      @(posedge clk); #1;
      e = sb8.pop_front();
      n_checks++;
      if ({v8, idx8, oh8, none8} !== e)
        $display("FAIL random_%0d: got %b want %b", k, {v8, idx8, oh8, none8}, e);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_rr_sweep();
    test_stall();
    test_reset_mid_hold();
    test_wrap5();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/priority_arbiter.md
PRIORITY_ARBITER -- requirements
Module: priority_arbiter

Interface
REQ-001 The block SHALL take parameter N, default 8, the number of request lines, legal range 2..32.
REQ-002 The block SHALL take parameter W, default $clog2(N), the grant index width, derived from N and not overridden.
REQ-003 The block SHALL provide port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL provide port req  input  N  request lines, bit i high = requester i pending.
REQ-006 The block SHALL provide port mode  input  1  arbitration mode: 0 = fixed priority, 1 = round-robin.
REQ-007 The block SHALL provide port out_ready  input  1  consumer accepts the current grant.
REQ-008 The block SHALL provide port out_valid  output  1  grant_idx and grant_onehot are valid.
REQ-009 The block SHALL provide port grant_idx  output  W  binary index of the granted requester.
REQ-010 The block SHALL provide port grant_onehot  output  N  one-hot form of grant_idx; all zero when out_valid=0.
REQ-011 The block SHALL provide port none  output  1  high when the last selection cycle saw req == 0 and no grant is pending.

Function
REQ-012 The block SHALL implement two states: IDLE (no grant pending) and HOLD (out_valid=1, awaiting out_ready).
REQ-013 A selection cycle SHALL be any IDLE cycle, and any HOLD cycle with out_ready=1 (handshake).
REQ-014 In a selection cycle with req != 0 the block SHALL register the winner and be in HOLD from the next cycle: latency 1 from req to out_valid.
REQ-015 In a selection cycle with req == 0 the block SHALL go to or stay in IDLE, with out_valid=0, grant_onehot=0, grant_idx unchanged and none=1.
REQ-016 In fixed mode the highest-index set req bit SHALL win (req=4'b0110 -> index 2).
REQ-017 In round-robin mode the first set req bit at or above pointer ptr SHALL win, searching upward and wrapping from N-1 to 0.
REQ-018 ptr SHALL update only on a handshake, to (grant_idx+1) mod N, so index N-1 wraps to 0 for non-power-of-2 N.
REQ-019 ptr SHALL be held unchanged when mode=0 and when no handshake occurs.
REQ-020 mode SHALL be sampled only in selection cycles; changing it in HOLD SHALL NOT alter the pending grant.
REQ-021 In HOLD with out_ready=0, grant_idx, grant_onehot and out_valid SHALL stay stable even if req changes or drops; grants are never retracted.
REQ-022 On a handshake with req != 0 the next grant SHALL be issued back-to-back, with out_valid staying high and no bubble.
REQ-023 The handshake request SHALL use the current-cycle req, including the just-granted bit; in round-robin mode the pointer excludes it from first choice.
REQ-024 none SHALL be 0 whenever out_valid=1.

Reset
REQ-025 While rst_n=0, asynchronously: state=IDLE, out_valid=0, grant_idx=0, grant_onehot=0, none=1, ptr=0.
REQ-026 Reset asserted mid-HOLD SHALL drop the pending grant with no handshake, and ptr SHALL return to 0.
REQ-027 After rst_n deasserts, the first rising edge SHALL be a normal selection cycle.

Structure
REQ-028 A shared package SHALL hold the mode typedef (MODE_FIXED=0, MODE_RR=1) and the state typedef (IDLE, HOLD).
REQ-029 A combinational sub-module priority_pick SHALL take N-bit req, start index and mode and return winner index plus any-flag.
REQ-030 priority_arbiter SHALL instantiate priority_pick once; all registers (state, ptr, outputs) SHALL live in priority_arbiter.

Verification
REQ-031 Reset: rst_n=0 then release with req=0 -> out_valid=0, none=1, grant_onehot=0.
REQ-032 Fixed, N=8: req=8'b0010_0110, out_ready=1 held -> grant_idx=5 every cycle after first, out_valid continuous.
REQ-033 Round-robin, N=8: req=8'hFF, out_ready=1 -> grant_idx sequence 0,1,2,...,7,0 with no bubble.
REQ-034 Round-robin wrap, N=5: req=5'b10001, ptr at 4 -> grants 4, 0, 4, 0.
REQ-035 Stall: grant 3 pending, out_ready=0 for 4 cycles while req goes to 0 and mode toggles -> grant_idx=3 stable, then handshake -> out_valid=0, none=1.
REQ-036 Reset mid-HOLD in round-robin after grants 0,1 -> outputs cleared; next req=8'hFF grants index 0.
